// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pipe_hazard_ctrl
// Purpose  : Central stall/flush controller for a 5-stage pipeline. It drives
//            the enable/clear of every pipeline register and the PC enable. It
//            detects load-use hazards and taken branches/jumps resolved in EX.
//            It also sequences multi-cycle data-memory accesses through a
//            req/ready handshake, with a wait FSM and a timeout.
// Ports    : clk, rst (async, active-high)
//            ID_rs1/ID_rs2/ID_use_rs2     - operands of the instruction in ID
//            EX_rd/EX_MemRead/EX_take     - instruction in EX (load, redirect)
//            MEM_MemRead/MEM_MemWrite     - access in MEM
//            dmem_ready / dmem_req        - data-memory handshake
//            PC_en, <stage>_en/<stage>_clear - pipeline register controls
//            err                          - sticky memory-timeout error
//            stall_cnt/flush_cnt          - perf counters (PIPE_HAZARD_PERF_EN)
// Options  : `define PIPE_HAZARD_PERF_EN adds saturating stall/flush counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs2,
  input  logic [4:0]       EX_rd,
  input  logic             EX_MemRead,
  input  logic             EX_take,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             PC_en,
  output logic             IF_ID_en,
  output logic             IF_ID_clear,
  output logic             ID_EX_en,
  output logic             ID_EX_clear,
  output logic             EX_MEM_en,
  output logic             EX_MEM_clear,
  output logic             MEM_WB_en,
  output logic             MEM_WB_clear,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             err
);

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  // The wait counter only has to reach TIMEOUT; it saturates if TIMEOUT is 0.
  localparam int              WCNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] C_TMO_CNT = WCNT_W'(TIMEOUT);
  localparam logic [WCNT_W-1:0] C_WCNT_MAX = '1;

  logic [1:0]        r_state, w_state_nxt;
  logic [WCNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic              r_err, w_err_nxt;
  logic              w_mem, w_load_use, w_hold, w_flush;

  assign w_mem      = MEM_MemRead | MEM_MemWrite;
  assign w_load_use = EX_MemRead && (EX_rd != 5'd0) &&
                      ((EX_rd == ID_rs1) || (ID_use_rs2 && (EX_rd == ID_rs2)));

  // In WAIT the access is already outstanding, so only ready releases it.
  assign w_hold = (r_state == WAIT) ? !dmem_ready
                                    : ((r_state == RUN) && w_mem && !dmem_ready);

  always_comb begin
    dmem_req       = 1'b0;
    PC_en          = 1'b1;
    IF_ID_en       = 1'b1;
    IF_ID_clear    = 1'b0;
    ID_EX_en       = 1'b1;
    ID_EX_clear    = 1'b0;
    EX_MEM_en      = 1'b1;
    EX_MEM_clear   = 1'b0;
    MEM_WB_en      = 1'b1;
    MEM_WB_clear   = 1'b0;
    w_flush        = 1'b0;
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_err_nxt      = r_err;

    if (rst) begin
      // Async reset gating: drop the request and clear every stage at once.
      PC_en        = 1'b0;
      IF_ID_en     = 1'b0;
      ID_EX_en     = 1'b0;
      EX_MEM_en    = 1'b0;
      MEM_WB_en    = 1'b0;
      IF_ID_clear  = 1'b1;
      ID_EX_clear  = 1'b1;
      EX_MEM_clear = 1'b1;
      MEM_WB_clear = 1'b1;
    end else begin
      case (r_state)
        RUN, WAIT: begin
          dmem_req = w_mem;
          if (w_hold) begin
            // Freeze everything up to EX/MEM; WB receives a bubble. A taken
            // branch in EX stays latched in the frozen registers meanwhile.
            PC_en        = 1'b0;
            IF_ID_en     = 1'b0;
            ID_EX_en     = 1'b0;
            EX_MEM_en    = 1'b0;
            MEM_WB_clear = 1'b1;
            if (r_state == RUN) begin
              w_state_nxt    = WAIT;
              w_wait_cnt_nxt = {{(WCNT_W-1){1'b0}}, 1'b1};
            end else if ((TIMEOUT != 0) && (r_wait_cnt == C_TMO_CNT)) begin
              w_state_nxt = ERR;
              w_err_nxt   = 1'b1;
            end else if (r_wait_cnt != C_WCNT_MAX) begin
              w_wait_cnt_nxt = r_wait_cnt + 1'b1;
            end
          end else begin
            w_state_nxt    = RUN;
            w_wait_cnt_nxt = '0;
            if (EX_take) begin
              // The load-use victim in ID is squashed, so no stall is needed.
              w_flush     = 1'b1;
              IF_ID_clear = 1'b1;
              ID_EX_clear = 1'b1;
            end else if (w_load_use) begin
              PC_en       = 1'b0;
              IF_ID_en    = 1'b0;
              ID_EX_clear = 1'b1;
            end
          end
        end
        default: begin
          // ERR (and any illegal encoding): pipeline frozen until reset.
          PC_en     = 1'b0;
          IF_ID_en  = 1'b0;
          ID_EX_en  = 1'b0;
          EX_MEM_en = 1'b0;
          MEM_WB_en = 1'b0;
          w_state_nxt = ERR;
          w_err_nxt   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign err = r_err;

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!PC_en && (r_state != ERR) && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (w_flush && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire
